// File: rtl/psl_ctl_pkg.sv
// PSL control package: job commands,
// controller states and parity helper.
package psl_ctl_pkg;

  localparam logic [7:0] JCOM_RESET = 8'h80;
  localparam logic [7:0] JCOM_START = 8'h90;

  typedef enum logic [2:0] {
    S_IDLE,
    S_JRESET,
    S_JRESET_WAIT,
    S_JSTART,
    S_RUNNING,
    S_MM_WAIT
  } state_e;

  // Odd parity; narrower fields are zero-extended,
  // which leaves the parity unchanged.
  function automatic logic odd_par(
    input logic [63:0] v
  );
    return ~^v;
  endfunction

endpackage

// File: rtl/psl_timeout_counter.sv
// Saturating wait counter shared by the
// job-reset and MMIO wait states.
module psl_timeout_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam int W1 = CNT_W + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [W1-1:0]    w_next_cnt;

  assign w_next_cnt = {1'b0, r_cnt} + W1'(1);

  // Expired on the cycle whose count reaches limit.
  assign expired = enable &&
                   (w_next_cnt >= {1'b0, limit});

  // Count waiting cycles, restart on state entry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/psl_job_mmio_master.sv
// Host-side job control and single-shot
// MMIO initiator toward the AFU.
module psl_job_mmio_master
  import psl_ctl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        ha_pclock,
  input  logic        reset,
  input  logic        start_req,
  input  logic [0:63] start_ea,
  input  logic        mm_req_valid,
  output logic        mm_req_ready,
  input  logic        mm_req_rnw,
  input  logic        mm_req_dw,
  input  logic        mm_req_cfg,
  input  logic [0:23] mm_req_ad,
  input  logic [0:63] mm_req_data,
  output logic        mm_rsp_valid,
  output logic [0:63] mm_rsp_data,
  output logic        mm_rsp_timeout,
  output logic        mm_rsp_parerr,
  output logic        job_running,
  output logic        job_done,
  output logic        job_timeout,
  output logic        ha_jval,
  output logic [0:7]  ha_jcom,
  output logic        ha_jcompar,
  output logic [0:63] ha_jea,
  output logic        ha_jeapar,
  input  logic        ah_jrunning,
  input  logic        ah_jdone,
  output logic        ha_mmval,
  output logic        ha_mmcfg,
  output logic        ha_mmrnw,
  output logic        ha_mmdw,
  output logic [0:23] ha_mmad,
  output logic        ha_mmadpar,
  output logic [0:63] ha_mmdata,
  output logic        ha_mmdatapar,
  input  logic        ah_mmack,
  input  logic [0:63] ah_mmdata,
  input  logic        ah_mmdatapar
);

  state_e      r_state, w_next;
  logic        r_mmval, r_mmcfg;
  logic        r_mmrnw, r_mmdw;
  logic [0:23] r_mmad;
  logic        r_mmadpar;
  logic [0:63] r_mmdata;
  logic        r_mmdatapar;
  logic        r_ret_run, r_jpend;
  logic        r_rsp_valid, r_rsp_to;
  logic        r_rsp_par;
  logic [0:63] r_rsp_data;
  logic        r_done, r_to;
  logic [0:63] r_ea;
  logic        w_ready, w_accept, w_exp;
  logic        w_set_done, w_set_to;
  logic        w_rsp, w_rsp_to;
  logic        w_end_job, w_wait;
  state_e      w_ret;
  logic        w_unused;

  assign w_unused = ah_jrunning;

  assign w_ready = !reset &&
    ((r_state == S_IDLE && !start_req) ||
     r_state == S_RUNNING);
  assign w_accept = mm_req_valid && w_ready;
  assign w_wait = (r_state == S_JRESET_WAIT) ||
                  (r_state == S_MM_WAIT);
  assign w_end_job = r_ret_run &&
                     (r_jpend || ah_jdone);
  assign w_ret = w_end_job ? S_IDLE :
                 (r_ret_run ? S_RUNNING : S_IDLE);

  psl_timeout_counter #(
    .CNT_W(CNT_W)
  ) u_tmo (
    .clk    (ha_pclock),
    .reset  (reset),
    .clear  (w_next != r_state),
    .enable (w_wait),
    .limit  (CNT_W'(TIMEOUT_CYCLES)),
    .expired(w_exp)
  );

  // State register.
  always_ff @(posedge ha_pclock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and event decode.
  always_comb begin
    w_next     = r_state;
    w_set_done = 1'b0;
    w_set_to   = 1'b0;
    w_rsp      = 1'b0;
    w_rsp_to   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_req)     w_next = S_JRESET;
        else if (w_accept) w_next = S_MM_WAIT;
      end
      S_JRESET: w_next = S_JRESET_WAIT;
      S_JRESET_WAIT: begin
        if (ah_jdone) begin
          w_next = S_JSTART;
        end else if (w_exp) begin
          w_next   = S_IDLE;
          w_set_to = 1'b1;
        end
      end
      S_JSTART: w_next = S_RUNNING;
      S_RUNNING: begin
        if (w_accept) begin
          w_next = S_MM_WAIT;
        end else if (ah_jdone) begin
          w_next     = S_IDLE;
          w_set_done = 1'b1;
        end
      end
      S_MM_WAIT: begin
        if (ah_mmack || w_exp) begin
          w_rsp      = 1'b1;
          w_rsp_to   = !ah_mmack;
          w_next     = w_ret;
          w_set_done = w_end_job;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, response and sticky flags.
  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      r_mmval     <= 1'b0;
      r_mmcfg     <= 1'b0;
      r_mmrnw     <= 1'b0;
      r_mmdw      <= 1'b0;
      r_mmad      <= '0;
      r_mmadpar   <= 1'b0;
      r_mmdata    <= '0;
      r_mmdatapar <= 1'b0;
      r_ret_run   <= 1'b0;
      r_jpend     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_rsp_par   <= 1'b0;
      r_rsp_data  <= '0;
      r_done      <= 1'b0;
      r_to        <= 1'b0;
      r_ea        <= '0;
    end else begin
      r_mmval <= w_accept;
      if (w_accept) begin
        r_mmcfg     <= mm_req_cfg;
        r_mmrnw     <= mm_req_rnw;
        r_mmdw      <= mm_req_dw;
        r_mmad      <= mm_req_ad;
        r_mmadpar   <= odd_par(64'(mm_req_ad));
        r_mmdata    <= mm_req_data;
        r_mmdatapar <= odd_par(64'(mm_req_data));
        r_ret_run   <= (r_state == S_RUNNING);
        r_jpend     <= (r_state == S_RUNNING) &&
                       ah_jdone;
      end else if (r_state == S_MM_WAIT &&
                   ah_jdone) begin
        r_jpend <= 1'b1;
      end
      r_rsp_valid <= w_rsp;
      r_rsp_to    <= w_rsp_to;
      r_rsp_data  <= (ah_mmack && w_rsp && r_mmrnw) ?
                     ah_mmdata : '0;
      r_rsp_par   <= ah_mmack && w_rsp && r_mmrnw &&
        (ah_mmdatapar != odd_par(64'(ah_mmdata)));
      if (r_state == S_IDLE && start_req) begin
        r_done <= 1'b0;
        r_to   <= 1'b0;
        r_ea   <= start_ea;
      end
      if (w_set_done) r_done <= 1'b1;
      if (w_set_to)   r_to   <= 1'b1;
    end
  end

  assign mm_req_ready   = w_ready;
  assign mm_rsp_valid   = r_rsp_valid;
  assign mm_rsp_data    = r_rsp_data;
  assign mm_rsp_timeout = r_rsp_to;
  assign mm_rsp_parerr  = r_rsp_par;
  assign job_running    = (r_state == S_RUNNING);
  assign job_done       = r_done;
  assign job_timeout    = r_to;

  assign ha_jval = (r_state == S_JRESET) ||
                   (r_state == S_JSTART);
  assign ha_jcom =
    (r_state == S_JRESET) ? JCOM_RESET :
    (r_state == S_JSTART) ? JCOM_START : 8'h00;
  assign ha_jea = (r_state == S_JSTART) ? r_ea : '0;
  assign ha_jcompar = ha_jval &&
                      odd_par(64'(ha_jcom));
  assign ha_jeapar  = ha_jval &&
                      odd_par(64'(ha_jea));

  assign ha_mmval     = r_mmval;
  assign ha_mmcfg     = r_mmcfg;
  assign ha_mmrnw     = r_mmrnw;
  assign ha_mmdw      = r_mmdw;
  assign ha_mmad      = r_mmad;
  assign ha_mmadpar   = r_mmadpar;
  assign ha_mmdata    = r_mmdata;
  assign ha_mmdatapar = r_mmdatapar;

endmodule

// File: tb/tb_psl_job_mmio_master.sv
// Directed plus randomized bench for the
// PSL job/MMIO master.
module tb_psl_job_mmio_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_req;
  logic [0:63] start_ea;
  logic        mm_req_valid, mm_req_ready;
  logic        mm_req_rnw, mm_req_dw, mm_req_cfg;
  logic [0:23] mm_req_ad;
  logic [0:63] mm_req_data;
  logic        mm_rsp_valid;
  logic [0:63] mm_rsp_data;
  logic        mm_rsp_timeout, mm_rsp_parerr;
  logic        job_running, job_done, job_timeout;
  logic        ha_jval, ha_jcompar, ha_jeapar;
  logic [0:7]  ha_jcom;
  logic [0:63] ha_jea;
  logic        ah_jrunning, ah_jdone;
  logic        ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw;
  logic [0:23] ha_mmad;
  logic        ha_mmadpar, ha_mmdatapar;
  logic [0:63] ha_mmdata;
  logic        ah_mmack, ah_mmdatapar;
  logic [0:63] ah_mmdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psl_job_mmio_master #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(16)
  ) dut (
    .ha_pclock(clk),
    .reset(reset),
    .start_req(start_req),
    .start_ea(start_ea),
    .mm_req_valid(mm_req_valid),
    .mm_req_ready(mm_req_ready),
    .mm_req_rnw(mm_req_rnw),
    .mm_req_dw(mm_req_dw),
    .mm_req_cfg(mm_req_cfg),
    .mm_req_ad(mm_req_ad),
    .mm_req_data(mm_req_data),
    .mm_rsp_valid(mm_rsp_valid),
    .mm_rsp_data(mm_rsp_data),
    .mm_rsp_timeout(mm_rsp_timeout),
    .mm_rsp_parerr(mm_rsp_parerr),
    .job_running(job_running),
    .job_done(job_done),
    .job_timeout(job_timeout),
    .ha_jval(ha_jval),
    .ha_jcom(ha_jcom),
    .ha_jcompar(ha_jcompar),
    .ha_jea(ha_jea),
    .ha_jeapar(ha_jeapar),
    .ah_jrunning(ah_jrunning),
    .ah_jdone(ah_jdone),
    .ha_mmval(ha_mmval),
    .ha_mmcfg(ha_mmcfg),
    .ha_mmrnw(ha_mmrnw),
    .ha_mmdw(ha_mmdw),
    .ha_mmad(ha_mmad),
    .ha_mmadpar(ha_mmadpar),
    .ha_mmdata(ha_mmdata),
    .ha_mmdatapar(ha_mmdatapar),
    .ah_mmack(ah_mmack),
    .ah_mmdata(ah_mmdata),
    .ah_mmdatapar(ah_mmdatapar)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reset-then-start with AFU acking the reset.
  task automatic start_job(input logic [63:0] ea);
    start_req = 1'b1;
    start_ea  = ea;
    tick();
    start_req = 1'b0;
    chk("jrst_val", ha_jval, 1);
    chk("jrst_com", ha_jcom, 8'h80);
    chk("jrst_compar", ha_jcompar, ~^8'h80);
    chk("jrst_ea", ha_jea, 0);
    chk("jrst_done_clr", job_done, 0);
    tick();
    chk("jrst_1cyc", ha_jval, 0);
    tick();
    ah_jdone = 1'b1;
    tick();
    ah_jdone = 1'b0;
    chk("jst_val", ha_jval, 1);
    chk("jst_com", ha_jcom, 8'h90);
    chk("jst_compar", ha_jcompar, 1);
    chk("jst_ea", ha_jea, ea);
    chk("jst_eapar", ha_jeapar, ~^ea);
    tick();
    chk("run", job_running, 1);
    chk("run_ready", mm_req_ready, 1);
    chk("run_jval", ha_jval, 0);
  endtask

  // One MMIO transaction acked after dly cycles.
  task automatic mm_op(input logic rnw,
                       input logic dw,
                       input logic [23:0] ad,
                       input logic [63:0] wd,
                       input logic [63:0] rd,
                       input logic flip,
                       input int dly);
    logic [63:0] exp_data;
    exp_data = rnw ? rd : 64'h0;
    mm_req_valid = 1'b1;
    mm_req_rnw   = rnw;
    mm_req_dw    = dw;
    mm_req_cfg   = 1'b0;
    mm_req_ad    = ad;
    mm_req_data  = wd;
    #1;
    chk("req_ready", mm_req_ready, 1);
    tick();
    mm_req_valid = 1'b0;
    chk("mmval", ha_mmval, 1);
    chk("mmad", ha_mmad, ad);
    chk("mmadpar", ha_mmadpar, ~^ad);
    chk("mmrnw", ha_mmrnw, rnw);
    chk("mmdw", ha_mmdw, dw);
    if (!rnw) begin
      chk("mmdata", ha_mmdata, wd);
      chk("mmdatapar", ha_mmdatapar, ~^wd);
    end
    chk("busy_ready", mm_req_ready, 0);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("mmval_1cyc", ha_mmval, 0);
      chk("no_early_rsp", mm_rsp_valid, 0);
    end
    ah_mmack     = 1'b1;
    ah_mmdata    = rd;
    ah_mmdatapar = (~^rd) ^ flip;
    tick();
    ah_mmack = 1'b0;
    chk("rsp_valid", mm_rsp_valid, 1);
    chk("rsp_data", mm_rsp_data, exp_data);
    chk("rsp_parerr", mm_rsp_parerr, rnw & flip);
    chk("rsp_tmo", mm_rsp_timeout, 0);
    tick();
    chk("rsp_1cyc", mm_rsp_valid, 0);
  endtask

  initial begin
    int n;
    logic saw;
    logic r;
    logic f;
    logic [63:0] d;
    reset = 1'b1;
    start_req = 1'b0;
    start_ea = '0;
    mm_req_valid = 1'b0;
    mm_req_rnw = 1'b0;
    mm_req_dw = 1'b0;
    mm_req_cfg = 1'b0;
    mm_req_ad = '0;
    mm_req_data = '0;
    ah_jrunning = 1'b0;
    ah_jdone = 1'b0;
    ah_mmack = 1'b0;
    ah_mmdata = '0;
    ah_mmdatapar = 1'b0;
    tick();
    tick();
    chk("rst_running", job_running, 0);
    chk("rst_ready", mm_req_ready, 0);
    chk("rst_jval", ha_jval, 0);
    chk("rst_jcompar", ha_jcompar, 0);
    chk("rst_mmval", ha_mmval, 0);
    chk("rst_done", job_done, 0);
    reset = 1'b0;
    tick();
    chk("idle_ready", mm_req_ready, 1);

    // Job start with random address.
    start_job({$urandom, $urandom});

    // Directed write then reads.
    mm_op(1'b0, 1'b1, 24'h000010,
          64'hDEADBEEF_00000001, 64'h0, 1'b0, 2);
    mm_op(1'b1, 1'b1, 24'h000020, 64'h0,
          64'h0123456789ABCDEF, 1'b0, 1);
    mm_op(1'b1, 1'b1, 24'h000020, 64'h0,
          64'h0123456789ABCDEF, 1'b1, 1);

    // Randomized transactions.
    for (int k = 0; k < 8; k++) begin
      r = 1'($urandom);
      f = 1'($urandom);
      d = {$urandom, $urandom};
      mm_op(r, 1'($urandom), 24'($urandom),
            d, ~d, f, $urandom_range(0, 3));
    end

    // Stray ack and start_req in RUNNING.
    ah_mmack = 1'b1;
    start_req = 1'b1;
    tick();
    ah_mmack = 1'b0;
    start_req = 1'b0;
    tick();
    chk("stray_ack", mm_rsp_valid, 0);
    chk("start_ign_jval", ha_jval, 0);
    chk("start_ign_run", job_running, 1);

    // MMIO read timeout.
    mm_req_valid = 1'b1;
    mm_req_rnw = 1'b1;
    tick();
    mm_req_valid = 1'b0;
    n = 0;
    while (!mm_rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("mm_tmo_cycles", n, TMO);
    chk("mm_tmo_flag", mm_rsp_timeout, 1);
    chk("mm_tmo_data", mm_rsp_data, 0);
    chk("mm_tmo_ready", mm_req_ready, 1);
    chk("mm_tmo_run", job_running, 1);
    tick();

    // Job done while an MMIO is pending.
    mm_req_valid = 1'b1;
    mm_req_rnw = 1'b1;
    tick();
    mm_req_valid = 1'b0;
    ah_jdone = 1'b1;
    tick();
    ah_jdone = 1'b0;
    chk("pend_no_done", job_done, 0);
    ah_mmack = 1'b1;
    ah_mmdata = 64'h55;
    ah_mmdatapar = ~^64'h55;
    tick();
    ah_mmack = 1'b0;
    chk("pend_rsp", mm_rsp_valid, 1);
    chk("pend_rsp_data", mm_rsp_data, 64'h55);
    chk("pend_done", job_done, 1);
    chk("pend_idle", job_running, 0);
    tick();

    // Start wins over MMIO; reset never acked.
    start_req = 1'b1;
    start_ea = 64'h1234;
    mm_req_valid = 1'b1;
    #1;
    chk("start_wins_ready", mm_req_ready, 0);
    tick();
    start_req = 1'b0;
    mm_req_valid = 1'b0;
    chk("sw_jcom", ha_jcom, 8'h80);
    chk("sw_no_mmval", ha_mmval, 0);
    chk("sw_done_clr", job_done, 0);
    tick();
    n = 0;
    saw = 1'b0;
    while (!job_timeout && n < 40) begin
      tick();
      n++;
      if (ha_jval) saw = 1'b1;
    end
    chk("jtmo_cycles", n, TMO);
    chk("jtmo_no_start", saw, 0);
    chk("jtmo_ready", mm_req_ready, 1);
    chk("jtmo_run", job_running, 0);

    // Reset in the middle of an MMIO wait.
    start_job(64'hFEDC_BA98_7654_3210);
    chk("tmo_clr", job_timeout, 0);
    mm_req_valid = 1'b1;
    tick();
    mm_req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_mmval", ha_mmval, 0);
    chk("mrst_mmad", ha_mmad, 0);
    chk("mrst_run", job_running, 0);
    chk("mrst_ready", mm_req_ready, 0);
    reset = 1'b0;
    ah_mmack = 1'b1;
    ah_jdone = 1'b1;
    tick();
    ah_mmack = 1'b0;
    ah_jdone = 1'b0;
    chk("late_ack", mm_rsp_valid, 0);
    chk("late_done", job_done, 0);
    chk("late_ready", mm_req_ready, 1);
    tick();
    chk("late_ack2", mm_rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
